// File: rtl/game_state_fsm.sv
// game_state_fsm: round sequencer for the stickman runner. It steps through the
// waiting, playing and win/lose phases, counts collected coins and holds each
// result screen for a fixed number of frame ticks. Status is one-hot
// {waiting, playing, win, lose}.
`timescale 1ns/1ps
module game_state_fsm #(
  parameter int unsigned COIN_GOAL     = 10,
  parameter int unsigned RESULT_FRAMES = 180
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start_key,
  input  logic       coin_hit,
  input  logic       stickman_dead,
  output logic [3:0] status,
  output logic [7:0] score,
  output logic       game_rst
);

  localparam logic [7:0] GOAL       = 8'(COIN_GOAL);
  localparam logic [9:0] LAST_FRAME = 10'(RESULT_FRAMES - 1);

  // PREWAIT and WAIT both show as waiting. PREWAIT requires the start key to be
  // released for one tick, so a key held through a result screen cannot start
  // the next round by itself.
  typedef enum logic [2:0] {
    S_PREWAIT = 3'd0,
    S_WAIT    = 3'd1,
    S_PLAY    = 3'd2,
    S_WIN     = 3'd3,
    S_LOSE    = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       fsync1;
  logic       fsync2;
  logic       fsync3;
  logic       tick;
  logic       coin_d;
  logic       coin_rise;
  logic [7:0] score_next;
  logic [9:0] frame_cnt;
  logic [9:0] frame_cnt_next;
  logic       game_rst_next;
  logic [3:0] status_next;

  // Bring frame_clk into the Clk domain and turn its rising edge into a one-cycle
  // tick; also register coin_hit rising edges so a long overlap counts once.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fsync1    <= 1'b0;
      fsync2    <= 1'b0;
      fsync3    <= 1'b0;
      tick      <= 1'b0;
      coin_d    <= 1'b0;
      coin_rise <= 1'b0;
    end else begin
      fsync1    <= frame_clk;
      fsync2    <= fsync1;
      fsync3    <= fsync2;
      tick      <= fsync2 & ~fsync3;
      coin_d    <= coin_hit;
      coin_rise <= coin_hit & ~coin_d;
    end
  end

  // Next state, score, result-screen counter, restart pulse and status decode.
  always_comb begin
    state_next     = state;
    score_next     = score;
    frame_cnt_next = frame_cnt;
    game_rst_next  = 1'b0;
    case (state)
      S_PREWAIT: begin
        if (tick && !start_key) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (tick && start_key) begin
          state_next    = S_PLAY;
          score_next    = '0;
          game_rst_next = 1'b1;
        end
      end
      S_PLAY: begin
        if (coin_rise && (score != 8'hFF)) score_next = score + 8'd1;
        // The win test looks at the registered score, so WIN shows one cycle
        // after the goal is reached; a death in that same cycle still wins out.
        if (stickman_dead) begin
          state_next     = S_LOSE;
          frame_cnt_next = '0;
        end else if (score == GOAL) begin
          state_next     = S_WIN;
          frame_cnt_next = '0;
        end
      end
      S_WIN, S_LOSE: begin
        if (tick) begin
          if (frame_cnt == LAST_FRAME) begin
            state_next     = S_PREWAIT;
            frame_cnt_next = '0;
          end else begin
            frame_cnt_next = frame_cnt + 10'd1;
          end
        end
      end
      default: begin
        state_next     = S_PREWAIT;
        frame_cnt_next = '0;
      end
    endcase

    case (state_next)
      S_PLAY:  status_next = 4'b0100;
      S_WIN:   status_next = 4'b0010;
      S_LOSE:  status_next = 4'b0001;
      default: status_next = 4'b1000;
    endcase
  end

  // Registered state and outputs; status is decoded from the next state so it
  // is a flop output aligned with the state register.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= S_PREWAIT;
      status    <= 4'b1000;
      score     <= '0;
      frame_cnt <= '0;
      game_rst  <= 1'b0;
    end else begin
      state     <= state_next;
      status    <= status_next;
      score     <= score_next;
      frame_cnt <= frame_cnt_next;
      game_rst  <= game_rst_next;
    end
  end

endmodule

// File: tb/tb_game_state_fsm.sv
// tb_game_state_fsm: two instances (small goal, and a 255 goal with death tied
// low) driven by shared stimulus; a phase-level reference model pushes expected
// outputs per clock and an independent monitor pops and compares them.
`timescale 1ns/1ps
module tb_game_state_fsm;

  localparam logic [3:0]  ST_WAITING = 4'b1000;
  localparam logic [3:0]  ST_PLAYING = 4'b0100;
  localparam logic [3:0]  ST_WIN     = 4'b0010;
  localparam logic [3:0]  ST_LOSE    = 4'b0001;
  localparam logic [12:0] RST_E      = {4'b1000, 8'd0, 1'b0};

  logic       Clk;
  logic       Reset;
  logic       frame_clk;
  logic       start_key;
  logic       coin_hit;
  logic       dead_a;
  logic       dead_b;
  logic [3:0] status_a;
  logic [3:0] status_b;
  logic [7:0] score_a;
  logic [7:0] score_b;
  logic       game_rst_a;
  logic       game_rst_b;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [25:0] exp_q[$];

  // reference model state, per instance
  logic [3:0] m_status[2];
  bit         m_armed[2];
  int         m_score[2];
  int         m_frames[2];
  logic [3:0] fc_h;
  logic [1:0] coin_h;

  game_state_fsm #(.COIN_GOAL(3), .RESULT_FRAMES(4)) dut_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .coin_hit(coin_hit), .stickman_dead(dead_a),
    .status(status_a), .score(score_a), .game_rst(game_rst_a)
  );

  game_state_fsm #(.COIN_GOAL(255), .RESULT_FRAMES(6)) dut_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .start_key(start_key),
    .coin_hit(coin_hit), .stickman_dead(dead_b),
    .status(status_b), .score(score_b), .game_rst(game_rst_b)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check(input int i, input string name, input logic [12:0] got,
                       input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got status=%b score=%0d game_rst=%b expected status=%b score=%0d game_rst=%b",
               name, i, cycle, got[12:9], got[8:1], got[0], exp[12:9], exp[8:1], exp[0]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_status[i] = ST_WAITING;
      m_armed[i]  = 1'b0;
      m_score[i]  = 0;
      m_frames[i] = 0;
    end
    fc_h   = '0;
    coin_h = '0;
  endtask

  // One clock of a round: waiting needs a released-key tick then a pressed-key
  // tick; playing counts coins (capped at 255), death beats reaching the goal;
  // a result screen lasts the instance's frame limit in ticks.
  task automatic model_step(input int i, input bit tk, input bit inc, input bit key,
                            input bit dead, output logic [12:0] e);
    bit pulse;
    int old;
    int goal;
    int flim;
    pulse = 1'b0;
    old   = m_score[i];
    goal  = (i == 0) ? 3 : 255;
    flim  = (i == 0) ? 4 : 6;
    if (m_status[i] == ST_WAITING) begin
      if (!m_armed[i]) begin
        if (tk && !key) m_armed[i] = 1'b1;
      end else if (tk && key) begin
        m_status[i] = ST_PLAYING;
        m_score[i]  = 0;
        m_armed[i]  = 1'b0;
        pulse       = 1'b1;
      end
    end else if (m_status[i] == ST_PLAYING) begin
      if (inc && m_score[i] < 255) m_score[i] = m_score[i] + 1;
      if (dead) begin
        m_status[i] = ST_LOSE;
        m_frames[i] = 0;
      end else if (old == goal) begin
        m_status[i] = ST_WIN;
        m_frames[i] = 0;
      end
    end else if (tk) begin
      m_frames[i] = m_frames[i] + 1;
      if (m_frames[i] == flim) m_status[i] = ST_WAITING;
    end
    e = {m_status[i], 8'(m_score[i]), pulse};
  endtask

  // reference model: sampled inputs at each clock, expectations into the queue
  initial begin
    logic [12:0] e0;
    logic [12:0] e1;
    bit tk;
    bit inc;
    model_reset();
    forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
        model_reset();
        exp_q.delete();
        exp_q.push_back({RST_E, RST_E});
      end else begin
        // tick seen now comes from a frame_clk rise sampled three clocks back
        tk  = fc_h[2] & ~fc_h[3];
        inc = coin_h[0] & ~coin_h[1];
        model_step(0, tk, inc, start_key, dead_a, e0);
        model_step(1, tk, inc, start_key, dead_b, e1);
        exp_q.push_back({e1, e0});
        fc_h   = {fc_h[2:0], frame_clk};
        coin_h = {coin_h[0], coin_hit};
      end
    end
  end

  // monitor: compares registered outputs against the oldest expectation
  initial begin
    logic [25:0] e;
    forever begin
      @(negedge Clk);
      cycle++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(0, "scoreboard", {status_a, score_a, game_rst_a}, e[12:0]);
        check(1, "scoreboard", {status_b, score_b, game_rst_b}, e[25:13]);
      end
    end
  end

  // free-running vsync with random high/low widths
  initial begin
    frame_clk = 1'b0;
    forever begin
      cycles($urandom_range(6, 14));
      frame_clk = ~frame_clk;
    end
  end

  task automatic coin_pulse(input int hi, input int lo);
    coin_hit = 1'b1;
    cycles(hi);
    coin_hit = 1'b0;
    cycles(lo);
  endtask

  task automatic restart();
    start_key = 1'b0;
    cycles(40);
    start_key = 1'b1;
    cycles(40);
  endtask

  initial begin
    Reset     = 1'b0;
    start_key = 1'b1;
    coin_hit  = 1'b0;
    dead_a    = 1'b0;
    dead_b    = 1'b0;
    cycles(5);
    Reset = 1'b1;

    // key held from reset: no start until released for a tick
    cycles(100);
    restart();

    // win path on dut_a, then extra coins after the win
    repeat (3) coin_pulse(50, 10);
    repeat (2) coin_pulse(5, 5);

    // result screen times out with the key still held; then restart
    cycles(200);
    restart();

    // coin edge and death in the same cycle at score 2
    repeat (2) coin_pulse(5, 5);
    coin_hit = 1'b1;
    dead_a   = 1'b1;
    cycles(1);
    dead_a = 1'b0;
    cycles(4);
    coin_hit = 1'b0;
    cycles(5);
    cycles(200);
    restart();

    // asynchronous reset between clock edges during play
    repeat (2) coin_pulse(5, 5);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    check(0, "async_reset", {status_a, score_a, game_rst_a}, RST_E);
    check(1, "async_reset", {status_b, score_b, game_rst_b}, RST_E);
    cycles(3);
    Reset = 1'b1;
    cycles(60);
    restart();

    // saturation on dut_b: 300 coin edges
    repeat (300) coin_pulse($urandom_range(1, 3), $urandom_range(1, 3));
    cycles(100);

    // random play
    repeat (3000) begin
      @(negedge Clk);
      if ($urandom_range(0, 29) == 0) start_key = ~start_key;
      if ($urandom_range(0, 3) == 0) coin_hit = ~coin_hit;
      dead_a = ($urandom_range(0, 99) == 0);
    end

    cycles(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog simulation did not complete, got cycle %0d required completion", cycle);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
